// File: rtl/fetch_controller.sv
// fetch_controller: sequencing controller for the instruction-fetch stage.
// Drives the PC register, PC-select mux, IF/ID latch and instruction-memory
// request. It arbitrates branch redirects from EX/MEM, load-use stalls from ID
// and a variable-latency instruction memory.
//
// Ports:
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   stall_req           load-use stall request from the ID hazard unit
//   branch_taken        redirect request from EX/MEM
//   branch_target[31:0] redirect address from EX/MEM
//   imem_ready          instruction memory has data for the current request
//   imem_req            fetch request to instruction memory
//   pc_write            PC register load enable
//   pc_sel              PC mux select: 0 = PC+4, 1 = pc_target
//   pc_target[31:0]     address presented to the PC mux target input
//   ifid_write          IF/ID latch load enable
//   ifid_flush          IF/ID latch loads a bubble
//   fetch_state[2:0]    current FSM state encoding
//   fetch_count         instructions delivered to IF/ID (saturating)
//   stall_count         cycles spent in STALL (saturating)
//   timeout_err         sticky memory-timeout flag, cleared only by RST
module fetch_controller #(
    parameter int unsigned CNT_W             = 16,
    parameter int unsigned RESET_HOLD_CYCLES = 2,
    parameter int unsigned MAX_WAIT          = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic             pc_write,
    output logic             pc_sel,
    output logic [31:0]      pc_target,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [2:0]       fetch_state,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        FETCH    = 3'd1,
        WAIT_MEM = 3'd2,
        STALL    = 3'd3,
        REDIRECT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [31:0]      pending_q, pending_d;
    logic [CNT_W-1:0] fetch_cnt_q, stall_cnt_q;
    logic             timeout_q;
    logic             fetch_inc, stall_inc, timeout_set;
    logic             wait_expired;

    // The wait counter keeps running from WAIT_MEM into REDIRECT because both
    // states wait on the same in-flight read; >= keeps the bound safe there.
    assign wait_expired = (wait_cnt_q >= 8'(MAX_WAIT - 1));

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        pending_d   = pending_q;
        fetch_inc   = 1'b0;
        stall_inc   = 1'b0;
        timeout_set = 1'b0;
        imem_req    = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        pc_target   = branch_taken ? branch_target : pending_q;

        case (state_q)
            HOLD: begin
                pc_target = '0;
                if (hold_cnt_q >= 4'(RESET_HOLD_CYCLES - 1)) begin
                    state_d = FETCH;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_sel     = 1'b1;
                    pc_write   = 1'b1;
                    ifid_flush = 1'b1;
                end else if (imem_ready && !stall_req) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    fetch_inc  = 1'b1;
                end else if (stall_req) begin
                    state_d = STALL;
                end else begin
                    state_d    = WAIT_MEM;
                    wait_cnt_d = '0;
                end
            end
            WAIT_MEM: begin
                imem_req   = 1'b1;
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (branch_taken) begin
                    pending_d = branch_target;
                    state_d   = REDIRECT;
                end else if (imem_ready) begin
                    if (!stall_req) begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        fetch_inc  = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = STALL;
                    end
                end else if (wait_expired) begin
                    timeout_set = 1'b1;
                    state_d     = FETCH;
                end
            end
            STALL: begin
                stall_inc = 1'b1;
                if (branch_taken) begin
                    pc_sel     = 1'b1;
                    pc_write   = 1'b1;
                    ifid_flush = 1'b1;
                    state_d    = FETCH;
                end else if (!stall_req) begin
                    state_d = FETCH;
                end
            end
            REDIRECT: begin
                imem_req   = 1'b1;
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (branch_taken) begin
                    pending_d = branch_target;
                end
                // A branch arriving with completion is already on pc_target.
                if (imem_ready || wait_expired) begin
                    pc_sel      = 1'b1;
                    pc_write    = 1'b1;
                    ifid_flush  = 1'b1;
                    timeout_set = !imem_ready;
                    state_d     = FETCH;
                end
            end
            default: begin
                pc_target  = '0;
                hold_cnt_d = '0;
                state_d    = HOLD;
            end
        endcase

        if (RST) begin
            imem_req   = 1'b0;
            pc_write   = 1'b0;
            pc_sel     = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b0;
            pc_target  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            pending_q   <= '0;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            pending_q  <= pending_d;
            if (fetch_inc && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 1'b1;
            end
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign fetch_state = state_q;
    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
    assign timeout_err = timeout_q;

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequencing controller for the instruction-fetch stage: PC register, PC-select mux, PC+4 adder, instruction memory and IF/ID latch.
- Generates the PC write enable, the mux select and target, the IF/ID write and flush controls, and the instruction-memory request.
- Arbitrates three sources: branch redirects from EX/MEM, load-use stall requests from ID, and a variable-latency instruction memory.
- Sits beside the fetch datapath at the top level of the pipeline.

Parameters:
- CNT_W, 16: width of the fetch_count and stall_count performance counters.
- RESET_HOLD_CYCLES, 2: idle cycles after reset deassertion before the first fetch (1..15).
- MAX_WAIT, 8: maximum consecutive imem_ready-low cycles in a memory wait before timeout (1..255).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous reset, active-high.
- stall_req  in  1  load-use stall request from the ID hazard unit.
- branch_taken  in  1  PCSrc from EX/MEM; redirect request.
- branch_target  in  32  redirect address from EX/MEM.
- imem_ready  in  1  instruction memory has valid data for the current request.
- imem_req  out  1  fetch request to instruction memory.
- pc_write  out  1  PC register load enable.
- pc_sel  out  1  mux select: 0 = PC+4, 1 = pc_target.
- pc_target  out  32  address driven to the mux target input.
- ifid_write  out  1  IF/ID latch load enable.
- ifid_flush  out  1  IF/ID latch loads a bubble (NOP, 0x00000000).
- fetch_state  out  3  current FSM state encoding.
- fetch_count  out  CNT_W  instructions delivered to IF/ID; saturating.
- stall_count  out  CNT_W  cycles spent in STALL; saturating.
- timeout_err  out  1  sticky flag; set on memory timeout, cleared only by RST.

Behaviour:
- State encodings: HOLD=0, FETCH=1, WAIT_MEM=2, STALL=3, REDIRECT=4.
- RST has priority over all other inputs. Each RST cycle sets state=HOLD and clears the hold counter, wait counter, pending_target, both perf counters and timeout_err.
- During and after RST, all control outputs (imem_req, pc_write, pc_sel, ifid_write, ifid_flush) are 0 and pc_target=0.
- Control outputs are combinational from the current state and inputs. State, counters and pending_target are registered.
- pc_target = branch_target when branch_taken=1; otherwise pc_target = pending_target.
- Input priority in every non-HOLD state: branch_taken > imem_ready completion > stall_req.
- HOLD:
  - All control outputs are 0.
  - Stay in HOLD for exactly RESET_HOLD_CYCLES cycles after RST falls, then go to FETCH.
  - branch_taken and stall_req are ignored.
- FETCH (imem_req=1):
  - branch_taken: pc_sel=1, pc_write=1, ifid_flush=1; stay in FETCH. The in-flight read is discarded.
  - imem_ready and stall_req=0: pc_write=1, ifid_write=1, fetch_count+1; stay in FETCH (one instruction per cycle).
  - stall_req=1: pc_write=0, ifid_write=0; go to STALL.
  - Otherwise: go to WAIT_MEM and reset the wait counter to 0.
- WAIT_MEM (imem_req=1, wait counter +1 per cycle):
  - branch_taken: pending_target <= branch_target; go to REDIRECT.
  - imem_ready and stall_req=0: pc_write=1, ifid_write=1, fetch_count+1; go to FETCH.
  - imem_ready and stall_req=1: no writes; go to STALL. The same PC is refetched after the stall; reads are idempotent.
  - Wait counter reaches MAX_WAIT with imem_ready=0: timeout_err <= 1; go to FETCH to reissue. PC is unchanged.
- STALL (imem_req=0, pc_write=0, ifid_write=0, stall_count+1 per cycle):
  - branch_taken: same actions as a branch in FETCH; go to FETCH.
  - stall_req=0: go to FETCH.
- REDIRECT (imem_req=1; waiting for the discarded read to complete):
  - A new branch_taken overwrites pending_target; the latest branch wins.
  - imem_ready: pc_sel=1, pc_write=1, ifid_flush=1, ifid_write=0; go to FETCH. The returned word is dropped.
  - MAX_WAIT timeout: take the same redirect actions, set timeout_err, and go to FETCH.
- ifid_write and ifid_flush are never asserted in the same cycle. pc_sel=1 only when pc_write=1.
- Counters saturate at all-ones and do not wrap.
- Unused state encodings (5..7) go to HOLD on the next cycle.

Test Plan:
- RST high for 3 cycles, then low with RESET_HOLD_CYCLES=2 and imem_ready=1 → fetch_state=0 for 2 cycles after deassertion; imem_req first high on the 3rd cycle; pc_write/ifid_write high every cycle after that; fetch_count=5 after 5 fetch cycles.
- imem_ready low for 3 cycles, then high → state sequence FETCH, WAIT_MEM ×3, FETCH; exactly one pc_write pulse at completion; timeout_err=0.
- In WAIT_MEM, branch_taken=1 with target 0x00000040 for one cycle, imem_ready high 2 cycles later → pc_sel=1, pc_write=1, pc_target=0x00000040, ifid_flush=1 in the completion cycle; fetch_count unchanged.
- stall_req held 4 cycles during FETCH → pc_write=0, ifid_write=0, imem_req=0 for 4 cycles; stall_count=4; fetch resumes the next cycle.
- branch_taken and stall_req both high in FETCH, target 0x00000100 → branch wins: pc_write=1, pc_sel=1, ifid_flush=1; state stays FETCH.
- imem_ready held low with MAX_WAIT=8 → timeout_err=1 after 8 wait cycles; state returns to FETCH; flag stays 1 until RST; RST asserted mid-wait clears all state the following cycle.
